// File: rtl/ball_motion.sv
// Game-tick ball engine for a 640x480 field.
// Serve/play/score FSM with wall bounces and paddle hits.
module ball_motion #(
  parameter int SERVE_DELAY = 60,
  parameter int DX = 3,
  parameter int DY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] width,
  input  logic [5:0] wall_width,
  input  logic [5:0] ball_width,
  input  logic [8:0] length,
  input  logic [8:0] left_y,
  input  logic [8:0] right_y,
  input  logic       pause,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic       ball_direction,
  output logic       in_play,
  output logic       score_left,
  output logic       score_right
);

  typedef enum logic [1:0] {
    S_SERVE,
    S_PLAY,
    S_SCORED
  } state_t;

  localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CW-1:0] LAST = CW'(SERVE_DELAY - 1);
  localparam logic [10:0] DX11 = 11'(DX);
  localparam logic [10:0] DY11 = 11'(DY);
  localparam logic [10:0] FW = 11'd640;
  localparam logic [10:0] FH = 11'd480;
  localparam logic [10:0] XMAX = 11'd639;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [9:0] x_q, x_n;
  logic [8:0] y_q, y_n;
  logic dir_q, dir_n;
  logic vdir_q, vdir_n;
  logic sl_q, sl_n;
  logic sr_q, sr_n;
  logic ip_q, ip_n;

  logic [10:0] bx, by, bw, ww, pw;
  logic [10:0] len, ly, ry;
  logic [10:0] face, cx, cy;
  logic l_ovl, r_ovl;

  assign bx   = 11'(x_q);
  assign by   = 11'(y_q);
  assign bw   = 11'(ball_width);
  assign ww   = 11'(wall_width);
  assign pw   = 11'(width);
  assign len  = 11'(length);
  assign ly   = 11'(left_y);
  assign ry   = 11'(right_y);
  assign face = XMAX - pw;
  assign cx   = (FW - bw) >> 1;
  assign cy   = (FH - bw) >> 1;

  assign l_ovl = (by + bw > ly) && (by < ly + len);
  assign r_ovl = (by + bw > ry) && (by < ry + len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_SERVE;
      cnt    <= '0;
      x_q    <= 10'(cx);
      y_q    <= 9'(cy);
      dir_q  <= 1'b1;
      vdir_q <= 1'b0;
      sl_q   <= 1'b0;
      sr_q   <= 1'b0;
      ip_q   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      x_q    <= x_n;
      y_q    <= y_n;
      dir_q  <= dir_n;
      vdir_q <= vdir_n;
      sl_q   <= sl_n;
      sr_q   <= sr_n;
      ip_q   <= ip_n;
    end
  end

  // vdir_q: 1 = moving up
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = x_q;
    y_n     = y_q;
    dir_n   = dir_q;
    vdir_n  = vdir_q;
    sl_n    = 1'b0;
    sr_n    = 1'b0;
    if (pause) begin
      sl_n = sl_q;
      sr_n = sr_q;
    end else begin
      unique case (state)
        S_SERVE: begin
          if (cnt == LAST) begin
            state_n = S_PLAY;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_PLAY: begin
          if (vdir_q) begin
            if (by < ww + DY11) begin
              y_n    = 9'(ww);
              vdir_n = 1'b0;
            end else begin
              y_n = 9'(by - DY11);
            end
          end else begin
            if (by + bw + DY11 + ww > FH) begin
              y_n    = 9'(FH - ww - bw);
              vdir_n = 1'b1;
            end else begin
              y_n = 9'(by + DY11);
            end
          end
          if (dir_q) begin
            if (bx >= pw && bx < pw + DX11) begin
              if (l_ovl) begin
                x_n   = 10'(pw);
                dir_n = 1'b0;
              end else begin
                x_n = 10'(bx - DX11);
              end
            end else if (bx < pw) begin
              if (bx < DX11) begin
                x_n     = '0;
                state_n = S_SCORED;
                sr_n    = 1'b1;
              end else begin
                x_n = 10'(bx - DX11);
              end
            end else begin
              x_n = 10'(bx - DX11);
            end
          end else begin
            if (bx + bw <= face && bx + bw + DX11 > face) begin
              if (r_ovl) begin
                x_n   = 10'(face - bw);
                dir_n = 1'b1;
              end else begin
                x_n = 10'(bx + DX11);
              end
            end else if (bx + bw > face) begin
              if (bx + bw + DX11 > XMAX) begin
                x_n     = 10'(XMAX - bw);
                state_n = S_SCORED;
                sl_n    = 1'b1;
              end else begin
                x_n = 10'(bx + DX11);
              end
            end else begin
              x_n = 10'(bx + DX11);
            end
          end
        end
        S_SCORED: begin
          x_n     = 10'(cx);
          y_n     = 9'(cy);
          vdir_n  = 1'b0;
          state_n = S_SERVE;
          cnt_n   = '0;
        end
        default: begin
          state_n = S_SERVE;
          cnt_n   = '0;
        end
      endcase
    end
    ip_n = (state_n == S_PLAY);
  end

  assign ball_x         = x_q;
  assign ball_y         = y_q;
  assign ball_direction = dir_q;
  assign in_play        = ip_q;
  assign score_left     = sl_q;
  assign score_right    = sr_q;

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Game-tick ball engine that produces the ball position and heading consumed by both paddle controllers.
- Takes both paddle Y positions back as inputs.
- Resolves wall bounces, paddle hits and misses, then raises score pulses for the scoreboard.
- Runs a serve/play/score state machine; one update per clk edge, same game tick as the paddles, on a 640x480 field.

Parameters:
- SERVE_DELAY, 60, clk cycles the ball is held at centre before play starts (>=1).
- DX, 3, horizontal step per cycle in pixels (1..15).
- DY, 2, vertical step per cycle in pixels (0..15).

Ports:
- clk  input  1  game tick clock
- reset  input  1  asynchronous, active-high reset
- width  input  6  paddle width; left paddle face at x=width, right paddle face at x=639-width
- wall_width  input  6  thickness of top and bottom walls
- ball_width  input  6  ball square size
- length  input  9  paddle length
- left_y  input  9  left paddle top Y
- right_y  input  9  right paddle top Y
- pause  input  1  freeze all state while high
- ball_x  output  10  ball upper-left X
- ball_y  output  9  ball upper-left Y
- ball_direction  output  1  1 = heading left, 0 = heading right
- in_play  output  1  high in PLAY state
- score_left  output  1  one-cycle pulse: left player scored
- score_right  output  1  one-cycle pulse: right player scored

Behaviour:
- Reset (async, any state):
  - ball_x=(640-ball_width)>>1, ball_y=(480-ball_width)>>1.
  - ball_direction=1; internal vertical direction vdir=down.
  - state=SERVE, serve counter=0, score pulses=0, in_play=0.
- All outputs are registered.
- Arithmetic is unsigned with 11-bit intermediates. Every comparison is written additively (e.g. ball_x < width+DX), so no subtraction can underflow.
- pause=1: every register holds, no pulses, in every state.
- SERVE:
  - Ball held at centre; counter increments each cycle.
  - When counter==SERVE_DELAY-1: go to PLAY and clear the counter. in_play rises after exactly SERVE_DELAY edges.
- PLAY, each cycle. Vertical and horizontal updates are evaluated in parallel from current ball/paddle values:
  - Vertical up: if ball_y < wall_width+DY, then ball_y<=wall_width and vdir<=down; else ball_y-=DY.
  - Vertical down: if ball_y+ball_width+DY > 480-wall_width, then ball_y<=480-wall_width-ball_width and vdir<=up; else ball_y+=DY.
  - Left (direction=1), hit window ball_x>=width and ball_x<width+DX:
    - If overlap (ball_y+ball_width>left_y and ball_y<left_y+length): hit, ball_x<=width, direction<=0.
    - Otherwise no hit; step ball_x-=DX.
  - Left, ball already past the face (ball_x<width):
    - If ball_x<DX: ball_x<=0, go to SCORED with right scorer.
    - Otherwise ball_x-=DX. No hit check once past the face.
  - Left, elsewhere: ball_x-=DX.
  - Right (direction=0): mirror of left with F=639-width.
    - Hit window: ball_x+ball_width<=F and ball_x+ball_width+DX>F, with overlap against right_y.
    - Hit: ball_x<=F-ball_width, direction<=1.
    - Past the face: if ball_x+ball_width+DX>639, then ball_x<=639-ball_width and go to SCORED with left scorer.
  - Corner case: a paddle hit and a wall clamp in the same cycle both apply.
- SCORED, one cycle:
  - The matching score pulse is high for this cycle only.
  - Ball re-centred; vdir<=down.
  - direction unchanged, so the serve goes toward the conceding side.
  - Next state SERVE with counter=0.
- Reset in SCORED clears the pulse immediately.
- Score pulses are never both high, and are never high outside SCORED.
- The ball never moves in SERVE.

Test Plan:
- Tie-offs for all scenarios: width=10, wall_width=8, ball_width=8, length=80; DY=0 where noted.
1. Release reset -> ball (316,236), direction=1, in_play=0. in_play=1 after 60 edges; first PLAY edge gives ball_x=313.
2. Left hit (DY=0, left_y=200) -> x steps to 16,13,10; at x=10 the hit gives ball_x=10, direction=0, next edge ball_x=13.
3. Left miss (DY=0, left_y=300) -> x=10 no hit; then 7,4,1; then ball_x=0, score_right high one cycle; next edge ball (316,236), in SERVE, direction=1.
4. Top wall (DY=2, vdir=up, ball_y=9) -> ball_y=8, vdir down, next ball_y=10.
5. Right hit (DY=0, right_y=200, direction=0) -> ball_x clamps to 621, direction=1. With right_y=400 -> ball_x=631, score_left pulses.
6. pause asserted mid-play for 5 cycles -> all outputs frozen; assert reset mid-SCORED -> pulse drops immediately, reset values restored.
